// File: rtl/acc_share_arbiter.sv
// acc_share_arbiter: time-shares one pipelined FP32 accumulator among NumReq streams, one
// AccumulateCount-beat group per grant, and routes results back by tag. `define ACC_ARB_FIXED_PRIO_EN for fixed priority.
module acc_share_arbiter #(
  parameter int DataWidth            = 32,
  parameter int NumReq               = 4,
  parameter int ReqIdWidth           = 2,
  parameter int AccumulateCount      = 4,
  parameter int AccumulateCountWidth = 2,
  parameter int TagDepth             = 8
) (
  input  logic                        clk,
  input  logic                        aclr_n,
  input  logic [NumReq-1:0]           req_valid,
  input  logic [NumReq*DataWidth-1:0] req_data,
  output logic [NumReq-1:0]           req_rdy,
  output logic                        acc_in_valid,
  output logic [DataWidth-1:0]        acc_in_data,
  input  logic                        acc_in_rdy,
  input  logic                        acc_out_valid,
  input  logic [DataWidth-1:0]        acc_out_data,
  output logic                        acc_out_rdy,
  output logic [NumReq-1:0]           res_valid,
  output logic [DataWidth-1:0]        res_data,
  input  logic [NumReq-1:0]           res_rdy,
  output logic [ReqIdWidth-1:0]       grant_id,
  output logic                        busy
);

  localparam int TagIdxWidth = $clog2(TagDepth);
  localparam int PtrWidth    = TagIdxWidth + 1;
  localparam logic [PtrWidth-1:0] PtrOne    = {{(PtrWidth-1){1'b0}}, 1'b1};
  localparam logic [PtrWidth-1:0] PtrFull   = PtrWidth'(TagDepth);
  localparam logic [ReqIdWidth-1:0] ReqOne  = {{(ReqIdWidth-1){1'b0}}, 1'b1};
  localparam logic [ReqIdWidth-1:0] ReqLast = ReqIdWidth'(NumReq - 1);
  localparam logic [AccumulateCountWidth-1:0] BeatOne  = {{(AccumulateCountWidth-1){1'b0}}, 1'b1};
  localparam logic [AccumulateCountWidth-1:0] BeatLast = AccumulateCountWidth'(AccumulateCount - 1);

  typedef enum logic [0:0] {
    Idle   = 1'b0,
    Stream = 1'b1
  } state_t;

  state_t                         state;
  state_t                         stateNext;
  logic [ReqIdWidth-1:0]          grantId;
  logic [AccumulateCountWidth-1:0] beatCnt;
  logic [ReqIdWidth-1:0]          tagMem [TagDepth];
  logic [PtrWidth-1:0]            wrPtr;
  logic [PtrWidth-1:0]            rdPtr;
  logic [PtrWidth-1:0]            tagCount;
  logic                           tagEmpty;
  logic                           tagFull;
  logic [ReqIdWidth-1:0]          tagHead;
  logic [ReqIdWidth-1:0]          searchBase;
  logic                           winnerValid;
  logic [ReqIdWidth-1:0]          winnerId;
  logic                           winnerHit;
  int                             candIdx;
  logic                           grantEn;
  logic                           beat;
  logic                           lastBeat;
  logic                           popEn;

  // Pointers carry one extra wrap bit, so the difference is the occupancy directly.
  assign tagCount = wrPtr - rdPtr;
  assign tagEmpty = (tagCount == {PtrWidth{1'b0}});
  assign tagFull  = (tagCount == PtrFull);
  assign tagHead  = tagMem[rdPtr[TagIdxWidth-1:0]];

  assign grantEn  = (state == Idle) & winnerValid & ~tagFull;
  assign beat     = acc_in_valid & acc_in_rdy;
  assign lastBeat = beat & (beatCnt == BeatLast);
  assign popEn    = ~tagEmpty & acc_out_valid & res_rdy[tagHead];

  assign grant_id = grantId;
  assign busy     = (state == Stream) | ~tagEmpty;

`ifdef ACC_ARB_FIXED_PRIO_EN
  assign searchBase = {ReqIdWidth{1'b0}};
`else
  logic [ReqIdWidth-1:0] rrPtr;

  // Round-robin pointer moves just past the owner once its group completes
  always_ff @(posedge clk) begin
    if (!aclr_n) begin
      rrPtr <= {ReqIdWidth{1'b0}};
    end else if (lastBeat) begin
      rrPtr <= (grantId == ReqLast) ? {ReqIdWidth{1'b0}} : grantId + ReqOne;
    end else begin
      rrPtr <= rrPtr;
    end
  end

  assign searchBase = rrPtr;
`endif

  // Winner search: first valid requester at or after searchBase, wrapping
  always_comb begin
    winnerValid = 1'b0;
    winnerId    = {ReqIdWidth{1'b0}};
    winnerHit   = 1'b0;
    candIdx     = 0;
    for (int i = 0; i < NumReq; i++) begin
      candIdx     = (int'(searchBase) + i) % NumReq;
      winnerHit   = req_valid[candIdx] & ~winnerValid;
      winnerId    = winnerHit ? ReqIdWidth'(candIdx) : winnerId;
      winnerValid = winnerValid | req_valid[candIdx];
    end
  end

  // FSM next state
  always_comb begin
    stateNext = state;
    case (state)
      Idle: begin
        if (grantEn) stateNext = Stream;
        else         stateNext = Idle;
      end
      Stream: begin
        if (lastBeat) stateNext = Idle;
        else          stateNext = Stream;
      end
      default: stateNext = Idle;
    endcase
  end

  // Forward path: only the owner sees ready while streaming
  always_comb begin
    req_rdy      = {NumReq{1'b0}};
    acc_in_valid = 1'b0;
    acc_in_data  = {DataWidth{1'b0}};
    if (state == Stream) begin
      acc_in_valid     = req_valid[grantId];
      acc_in_data      = req_data[int'(grantId)*DataWidth +: DataWidth];
      req_rdy[grantId] = acc_in_rdy;
    end else begin
      req_rdy = {NumReq{1'b0}};
    end
  end

  // Return path: results go to the oldest outstanding tag; ignored when no tag is pending
  always_comb begin
    res_valid   = {NumReq{1'b0}};
    res_data    = {DataWidth{1'b0}};
    acc_out_rdy = 1'b0;
    if (!tagEmpty) begin
      res_valid[tagHead] = acc_out_valid;
      res_data           = acc_out_data;
      acc_out_rdy        = res_rdy[tagHead];
    end else begin
      acc_out_rdy = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!aclr_n) state <= Idle;
    else         state <= stateNext;
  end

  // Grant register, beat counter and tag FIFO pointers
  always_ff @(posedge clk) begin
    if (!aclr_n) begin
      grantId <= {ReqIdWidth{1'b0}};
      beatCnt <= {AccumulateCountWidth{1'b0}};
      wrPtr   <= {PtrWidth{1'b0}};
      rdPtr   <= {PtrWidth{1'b0}};
    end else begin
      if (grantEn) begin
        grantId <= winnerId;
        wrPtr   <= wrPtr + PtrOne;
      end
      if (popEn) begin
        rdPtr <= rdPtr + PtrOne;
      end
      if (beat) begin
        beatCnt <= lastBeat ? {AccumulateCountWidth{1'b0}} : beatCnt + BeatOne;
      end
    end
  end

  // Tag storage holds owner ids; contents are don't-care while empty
  always_ff @(posedge clk) begin
    if (grantEn) begin
      tagMem[wrPtr[TagIdxWidth-1:0]] <= winnerId;
    end
  end

endmodule

// File: tb/tb_acc_share_arbiter.sv
// Self-checking bench for acc_share_arbiter: a behavioural FP32 accumulator stands in for the ACC,
// requesters are fed from queues, and results are compared against per-requester expected sums.
module tb_acc_share_arbiter;
  localparam int DW  = 32;
  localparam int NR  = 4;
  localparam int IW  = 2;
  localparam int AC  = 4;
  localparam int TD  = 8;
  localparam int LAT = 3;

  logic             clk;
  logic             aclr_n;
  logic [NR-1:0]    req_valid, req_rdy, res_valid, res_rdy;
  logic [NR*DW-1:0] req_data;
  logic             acc_in_valid, acc_in_rdy, acc_out_valid, acc_out_rdy, busy;
  logic [DW-1:0]    acc_in_data, acc_out_data, res_data;
  logic [IW-1:0]    grant_id;

  logic [NR-1:0] envValid;
  logic [NR-1:0] reqEn;
  logic [31:0]   reqQ     [NR][$];
  logic [31:0]   expQ     [NR][$];
  logic [31:0]   recvData [NR][$];
  int            recvOrder[$];
  logic [31:0]   pipeQ[$];
  int            pipeT[$];
  real           accSum;
  int            accBeats;
  int            cyc;
  int            protoErr;
  int            nChecks;
  int            nPass;

  assign req_valid = envValid & reqEn;

  acc_share_arbiter #(
    .DataWidth(DW), .NumReq(NR), .ReqIdWidth(IW), .AccumulateCount(AC),
    .AccumulateCountWidth(2), .TagDepth(TD)
  ) dut (
    .clk(clk), .aclr_n(aclr_n),
    .req_valid(req_valid), .req_data(req_data), .req_rdy(req_rdy),
    .acc_in_valid(acc_in_valid), .acc_in_data(acc_in_data), .acc_in_rdy(acc_in_rdy),
    .acc_out_valid(acc_out_valid), .acc_out_data(acc_out_data), .acc_out_rdy(acc_out_rdy),
    .res_valid(res_valid), .res_data(res_data), .res_rdy(res_rdy),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic real f2r(input logic [31:0] b);
    logic [63:0] d;
    if (b[30:0] == 31'd0) d = {b[31], 63'd0};
    else                  d = {b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // ACC stand-in and requester/result bookkeeping, sampled on the pre-edge values
  initial begin : env
    logic          inBeat, outPop;
    logic [NR-1:0] reqFire, resFire;
    logic [31:0]   inData, outData;
    acc_out_valid = 1'b0;
    acc_out_data  = '0;
    envValid      = '0;
    req_data      = '0;
    accSum = 0.0; accBeats = 0; cyc = 0; protoErr = 0;
    forever begin
      @(posedge clk);
      inBeat  = acc_in_valid & acc_in_rdy;
      outPop  = acc_out_valid & acc_out_rdy;
      reqFire = req_valid & req_rdy;
      resFire = res_valid & res_rdy;
      inData  = acc_in_data;
      outData = res_data;
      if ($countones(req_rdy) > 1 || $countones(res_valid) > 1) protoErr++;
      cyc++;
      if (!aclr_n) begin
        accSum = 0.0; accBeats = 0;
        pipeQ.delete(); pipeT.delete();
      end else begin
        if (outPop) begin
          void'(pipeQ.pop_front());
          void'(pipeT.pop_front());
        end
        if (inBeat) begin
          accSum += f2r(inData);
          accBeats++;
          if (accBeats == AC) begin
            pipeQ.push_back(r2f(accSum));
            pipeT.push_back(cyc + LAT);
            accSum = 0.0; accBeats = 0;
          end
        end
        for (int i = 0; i < NR; i++) begin
          if (reqFire[i] && reqQ[i].size() > 0) void'(reqQ[i].pop_front());
          if (resFire[i]) begin
            recvData[i].push_back(outData);
            recvOrder.push_back(i);
          end
        end
      end
      #1;
      acc_out_valid = (pipeQ.size() > 0) && (pipeT[0] <= cyc);
      acc_out_data  = (pipeQ.size() > 0) ? pipeQ[0] : 32'd0;
      for (int i = 0; i < NR; i++) begin
        envValid[i] = (reqQ[i].size() > 0);
        req_data[i*DW +: DW] = (reqQ[i].size() > 0) ? reqQ[i][0] : 32'd0;
      end
    end
  end

  function automatic bit idleNow();
    bit q = 1'b1;
    for (int i = 0; i < NR; i++) if (reqQ[i].size() != 0) q = 1'b0;
    return q && (pipeQ.size() == 0) && (accBeats == 0) && (busy === 1'b0);
  endfunction

  function automatic int totalQueued();
    int s = 0;
    for (int i = 0; i < NR; i++) s += reqQ[i].size();
    return s;
  endfunction

  task automatic clearReqs();
    for (int i = 0; i < NR; i++) begin
      reqQ[i].delete(); expQ[i].delete(); recvData[i].delete();
    end
    recvOrder.delete();
    reqEn = '0;
  endtask

  task automatic doReset();
    @(negedge clk);
    aclr_n = 1'b0;
    clearReqs();
    res_rdy = '1;
    acc_in_rdy = 1'b1;
    repeat (2) @(negedge clk);
    reqEn = '1;
    aclr_n = 1'b1;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    res_rdy = '1; acc_in_rdy = 1'b1; reqEn = '1;
    @(negedge clk);
    while (!idleNow() && n < budget) begin
      @(negedge clk);
      n++;
    end
    nChecks++;
    if (n >= budget) $display("FAIL %s_drain: still busy=%b after %0d cycles, required idle", name, busy, n);
    else nPass++;
  endtask

  task automatic waitQ(input string name, input int r, input int left, input int budget);
    int n = 0;
    while (reqQ[r].size() > left && n < budget) begin
      @(negedge clk);
      n++;
    end
    nChecks++;
    if (n >= budget) $display("FAIL %s_wait: req%0d has %0d beats, required %0d", name, r, reqQ[r].size(), left);
    else nPass++;
  endtask

  task automatic pushRandGroup(input int r);
    int s = 0;
    int v;
    for (int k = 0; k < AC; k++) begin
      v = $urandom_range(0, 1023);
      s += v;
      reqQ[r].push_back(r2f(real'(v)));
    end
    expQ[r].push_back(r2f(real'(s)));
  endtask

  task automatic test_reset();
    aclr_n = 1'b0;
    reqEn = '1;
    for (int i = 0; i < NR; i++) repeat (AC) reqQ[i].push_back(32'h43C80000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    nChecks++; if (req_rdy !== 4'b0000) $display("FAIL reset_req_rdy: got %b expected 0000", req_rdy); else nPass++;
    nChecks++; if (acc_in_valid !== 1'b0) $display("FAIL reset_acc_in_valid: got %b expected 0", acc_in_valid); else nPass++;
    nChecks++; if (res_valid !== 4'b0000) $display("FAIL reset_res_valid: got %b expected 0000", res_valid); else nPass++;
    nChecks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else nPass++;
    nChecks++; if (grant_id !== 2'd0) $display("FAIL reset_grant_id: got %0d expected 0", grant_id); else nPass++;
    nChecks++; if (acc_out_rdy !== 1'b0) $display("FAIL reset_acc_out_rdy: got %b expected 0", acc_out_rdy); else nPass++;
    clearReqs();
    @(negedge clk);
    reqEn = '1; res_rdy = '1;
    aclr_n = 1'b1;
  endtask

  task automatic test_single();
    doReset();
    reqQ[0].push_back(32'h43C88000);
    repeat (3) reqQ[0].push_back(32'h43C80000);
    drain("single", 100);
    nChecks++;
    if (recvData[0].size() != 1 || recvOrder.size() != 1)
      $display("FAIL single_count: got %0d results (%0d total) expected 1", recvData[0].size(), recvOrder.size());
    else begin
      nPass++;
      nChecks++;
      if (recvData[0][0] !== 32'h44C82000) $display("FAIL single_sum: got %h expected 44c82000", recvData[0][0]); else nPass++;
    end
    nChecks++; if (grant_id !== 2'd0) $display("FAIL single_grant: got %0d expected 0", grant_id); else nPass++;
  endtask

  task automatic test_round_robin();
    int expOrd[4] = '{0, 2, 0, 2};
    doReset();
    repeat (2 * AC) begin
      reqQ[0].push_back(32'h43C80000);
      reqQ[2].push_back(32'h43C80000);
    end
    drain("rr", 200);
    nChecks++;
    if (recvOrder.size() != 4) $display("FAIL rr_count: got %0d results expected 4", recvOrder.size());
    else begin
      nPass++;
      for (int k = 0; k < 4; k++) begin
        nChecks++;
        if (recvOrder[k] != expOrd[k]) $display("FAIL rr_order[%0d]: got %0d expected %0d", k, recvOrder[k], expOrd[k]); else nPass++;
      end
      for (int k = 0; k < 2; k++) begin
        nChecks++;
        if (recvData[0][k] !== 32'h44C80000 || recvData[2][k] !== 32'h44C80000)
          $display("FAIL rr_sum[%0d]: got %h/%h expected 44c80000", k, recvData[0][k], recvData[2][k]);
        else nPass++;
      end
    end
  endtask

  task automatic test_backpressure();
    doReset();
    reqQ[1].push_back(32'h3F800000); reqQ[1].push_back(32'h40000000);
    reqQ[1].push_back(32'h40400000); reqQ[1].push_back(32'h40800000);
    repeat (AC) reqQ[3].push_back(32'h42C80000);
    waitQ("bp", 1, 2, 50);
    acc_in_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      nChecks++;
      if (req_rdy !== 4'b0000 || grant_id !== 2'd1 || acc_in_valid !== 1'b1)
        $display("FAIL bp_stall[%0d]: got rdy=%b gid=%0d v=%b expected 0000/1/1", c, req_rdy, grant_id, acc_in_valid);
      else nPass++;
    end
    nChecks++; if (reqQ[1].size() != 2) $display("FAIL bp_hold: got %0d beats left expected 2", reqQ[1].size()); else nPass++;
    acc_in_rdy = 1'b1;
    @(negedge clk);
    nChecks++;
    if (req_rdy !== 4'b0010 || reqQ[1].size() != 1)
      $display("FAIL bp_resume: got rdy=%b left=%0d expected 0010/1", req_rdy, reqQ[1].size());
    else nPass++;
    drain("bp", 200);
    nChecks++;
    if (recvOrder.size() != 2 || recvOrder[0] != 1 || recvOrder[1] != 3 ||
        recvData[1].size() != 1 || recvData[3].size() != 1)
      $display("FAIL bp_order: got %0d results expected owners 1,3", recvOrder.size());
    else begin
      nPass++;
      nChecks++;
      if (recvData[1][0] !== 32'h41200000 || recvData[3][0] !== 32'h43C80000)
        $display("FAIL bp_sum: got %h/%h expected 41200000/43c80000", recvData[1][0], recvData[3][0]);
      else nPass++;
    end
  endtask

  task automatic test_full();
    int n = 0;
    int expOrd[9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
    doReset();
    res_rdy = '0;
    for (int r = 0; r < NR; r++) repeat (2 * AC) reqQ[r].push_back(32'h43C80000);
    repeat (AC) reqQ[0].push_back(32'h43C80000);
    while (totalQueued() > AC && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    nChecks++; if (reqQ[0].size() != AC) $display("FAIL full_no_grant: got %0d beats left expected %0d", reqQ[0].size(), AC); else nPass++;
    nChecks++;
    if (req_rdy !== 4'b0000 || acc_in_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL full_idle: got rdy=%b v=%b busy=%b expected 0000/0/1", req_rdy, acc_in_valid, busy);
    else nPass++;
    nChecks++;
    if (res_valid !== 4'b0001 || acc_out_rdy !== 1'b0)
      $display("FAIL full_head: got res_valid=%b out_rdy=%b expected 0001/0", res_valid, acc_out_rdy);
    else nPass++;
    res_rdy = 4'b0001;
    @(negedge clk);
    res_rdy = 4'b0000;
    waitQ("full_ninth", 0, 0, 60);
    drain("full", 300);
    nChecks++;
    if (recvOrder.size() != 9) $display("FAIL full_count: got %0d results expected 9", recvOrder.size());
    else begin
      nPass++;
      for (int k = 0; k < 9; k++) begin
        nChecks++;
        if (recvOrder[k] != expOrd[k]) $display("FAIL full_order[%0d]: got %0d expected %0d", k, recvOrder[k], expOrd[k]); else nPass++;
      end
      nChecks++;
      if (recvData[0][2] !== 32'h44C80000) $display("FAIL full_sum: got %h expected 44c80000", recvData[0][2]); else nPass++;
    end
  endtask

  task automatic test_mid_reset();
    doReset();
    repeat (AC) reqQ[1].push_back(32'h42C80000);
    waitQ("midrst", 1, 2, 50);
    aclr_n = 1'b0;
    clearReqs();
    @(negedge clk);
    nChecks++;
    if (busy !== 1'b0 || res_valid !== 4'b0000 || req_rdy !== 4'b0000 || acc_in_valid !== 1'b0)
      $display("FAIL midrst_idle: got busy=%b res=%b rdy=%b v=%b expected all 0", busy, res_valid, req_rdy, acc_in_valid);
    else nPass++;
    reqEn = '1;
    aclr_n = 1'b1;
    reqQ[1].push_back(32'h3F800000); reqQ[1].push_back(32'h40000000);
    reqQ[1].push_back(32'h40400000); reqQ[1].push_back(32'h40800000);
    drain("midrst", 100);
    nChecks++;
    if (recvOrder.size() != 1 || recvData[1].size() != 1)
      $display("FAIL midrst_count: got %0d results expected 1", recvOrder.size());
    else begin
      nPass++;
      nChecks++;
      if (recvData[1][0] !== 32'h41200000) $display("FAIL midrst_sum: got %h expected 41200000", recvData[1][0]); else nPass++;
    end
  endtask

  task automatic test_random();
    doReset();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) pushRandGroup($urandom_range(0, NR - 1));
      res_rdy    = NR'($urandom);
      acc_in_rdy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NR; i++) reqEn[i] = ($urandom_range(0, 4) != 0);
    end
    drain("rand", 3000);
    for (int r = 0; r < NR; r++) begin
      nChecks++;
      if (recvData[r].size() != expQ[r].size())
        $display("FAIL rand_count[%0d]: got %0d results expected %0d", r, recvData[r].size(), expQ[r].size());
      else begin
        nPass++;
        for (int k = 0; k < expQ[r].size(); k++) begin
          nChecks++;
          if (recvData[r][k] !== expQ[r][k])
            $display("FAIL rand_sum[%0d][%0d]: got %h expected %h", r, k, recvData[r][k], expQ[r][k]);
          else nPass++;
        end
      end
    end
    nChecks++;
    if (protoErr != 0) $display("FAIL onehot: got %0d cycles with multiple rdy/valid bits expected 0", protoErr); else nPass++;
  endtask

  initial begin
    clk = 1'b0; aclr_n = 1'b0; acc_in_rdy = 1'b1; res_rdy = '1; reqEn = '0;
    nChecks = 0; nPass = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_full();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
